instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Instruction-fetch stage of the MIPS core: holds the PC, reads one word per instruction from IMEM over a req/gnt/rvalid handshake.
//  Presents the word to decode with valid/ready; pre-slices opcode[31:26] and imm16[15:0] for the downstream 16->32 immediate extender.
//  Accepts branch/jump redirects from execute; discards any in-flight fetch on redirect.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC loaded on reset
//  ADDR_W    32             PC / IMEM address width
// PORTS
//  clk             in   1       single clock, rising edge
//  rst_n           in   1       synchronous active-low reset
//  imem_req        out  1       fetch request, held until imem_gnt
//  imem_addr       out  ADDR_W  fetch address (= pc while imem_req)
//  imem_gnt        in   1       request accepted this cycle
//  imem_rvalid     in   1       read data valid (>=1 cycle after gnt)
//  imem_rdata      in   32      instruction word
//  id_valid        out  1       instruction presented to decode
//  id_ready        in   1       decode accepts this cycle
//  id_instr        out  32      instruction word
//  id_pc           out  ADDR_W  address of id_instr
//  id_pc4          out  ADDR_W  id_pc + 4 (link value for jal)
//  id_opcode       out  6       id_instr[31:26]
//  id_imm16        out  16      id_instr[15:0]
//  redirect_valid  in   1       branch/jump taken
//  redirect_pc     in   ADDR_W  new fetch address
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge): pc=RESET_PC, state=S_REQ, drop=0, imem_req=0 that cycle, id_valid=0, id_instr=32'h0 (NOP), id_pc=id_pc4=0.
//  FSM: S_REQ -> imem_req=1, imem_addr=pc; on imem_gnt -> S_WAIT.
//       S_WAIT -> on imem_rvalid: if drop, clear drop, -> S_REQ; else latch rdata, id_pc=pc, id_pc4=pc+4, pc=pc+4, -> S_HOLD.
//       S_HOLD -> id_valid=1; on id_ready -> S_REQ next cycle.
//  Outputs id_* registered; stable and unchanged while id_valid && !id_ready.
//  Min latency: req+gnt cycle T -> rvalid T+1 -> id_valid T+2; max one instr per 3 cycles.
//  Redirect (any state, highest priority): pc=redirect_pc at that edge.
//    S_REQ, no gnt: next req uses redirect_pc, no extra cycle.
//    S_REQ with gnt same cycle: old fetch in flight -> S_WAIT, drop=1.
//    S_WAIT (no rvalid): drop=1; response discarded when it arrives.
//    S_WAIT with rvalid same cycle: response discarded, -> S_REQ.
//    S_HOLD: held instr killed, id_valid=0 next cycle, -> S_REQ; same-cycle id_ready does NOT count as transfer.
//  pc+4 wraps modulo 2^ADDR_W (32'hFFFF_FFFC -> 0); no fault.
//  imem_rvalid outside S_WAIT ignored. At most one outstanding fetch.
//  Reset mid-fetch: outstanding response after reset ignored (state S_REQ, not S_WAIT).
// CONFIGURATION
//  IF_ALIGN_CHECK_EN defined: extra output if_misalign (1 bit, reset 0); redirect_pc[1:0]!=0 -> redirect ignored
//    (pc unchanged, fetch continues), if_misalign pulses 1 for one cycle.
//  Undefined: no if_misalign port; redirect_pc[1:0] forced to 2'b00 before load.
// STRUCTURE
//  Shared package mips_pkg: opcode constants (addi, addiu, andi, ori, xori, lui, lw, sw, beq, bne, slti, sltiu, j, jal),
//    fetch state enum {S_REQ,S_WAIT,S_HOLD}, INSTR_NOP=32'h0, RESET_PC default.
//  One sub-module: fetch_pc_reg (pc register, +4 incrementer, redirect mux, align check).
// TESTING
//  1 Reset, gnt=1 same cycle, rvalid 1 cycle later, id_ready=1: id_pc 0,4,8 each 3 cycles; id_instr=rdata; id_pc4=id_pc+4.
//  2 rdata=32'h2008FFFF (addi) held, id_ready=0 for 5 cycles: id_opcode=6'b001000, id_imm16=16'hFFFF stable, no imem_req issued.
//  3 redirect_pc=32'h0000_0100 while S_WAIT, rvalid 3 cycles later with 32'hDEADBEEF: discarded, next imem_addr=32'h100.
//  4 redirect in S_HOLD with id_ready=1 same cycle: id_valid=0 next cycle, next imem_addr=redirect_pc, old instr not re-presented.
//  5 pc=32'hFFFF_FFFC fetched: id_pc4=0, next imem_addr=0.
//  6 IF_ALIGN_CHECK_EN: redirect_pc=32'h102 -> if_misalign 1 cycle, fetch proceeds at pc+4; undefined: fetch at 32'h100.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: opcodes, fetch-stage state encoding and reset constants.
package mips_pkg;

    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_e;

    localparam logic [31:0] INSTR_NOP        = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// IMEM request/response bus between the fetch stage (master) and instruction memory (slave).
interface instr_fetch_unit_if #(
    parameter int ADDR_W = 32
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_gnt;
    logic              imem_rvalid;
    logic [31:0]       imem_rdata;

    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata
    );
endinterface

// File: rtl/fetch_pc_reg.sv
// Program counter with +4 incrementer and redirect mux; IF_ALIGN_CHECK_EN rejects misaligned redirects.
import mips_pkg::*;

module fetch_pc_reg #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              advance,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc4,
    output logic              redirect_take
`ifdef IF_ALIGN_CHECK_EN
    , output logic            misalign
`endif
);

    logic [ADDR_W-1:0] target;

    // NOTE: low address bits are cleared rather than trusted, so pc stays word aligned.
    assign target = redirect_pc & ~ADDR_W'(3);
    assign pc4    = pc + ADDR_W'(4);

`ifdef IF_ALIGN_CHECK_EN
    assign redirect_take = redirect_valid && (redirect_pc[1:0] == 2'b00);

    always_ff @(posedge clk) begin
        if (!rst_n) misalign <= 1'b0;
        else        misalign <= redirect_valid && (redirect_pc[1:0] != 2'b00);
    end
`else
    assign redirect_take = redirect_valid;
`endif

    // NOTE: reset is synchronous and sampled here; all state uses non-blocking assignments.
    always_ff @(posedge clk) begin
        if (!rst_n)             pc <= RESET_PC;
        else if (redirect_take) pc <= target;
        else if (advance)       pc <= pc4;
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// MIPS instruction-fetch stage: IMEM req/gnt/rvalid fetch, valid/ready hand-off to decode,
// redirect with in-flight discard. Optional IF_ALIGN_CHECK_EN adds the if_misalign output.
import mips_pkg::*;

module instr_fetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    instr_fetch_unit_if.master        imem,
    output logic                      id_valid,
    input  logic                      id_ready,
    output logic [31:0]               id_instr,
    output logic [ADDR_W-1:0]         id_pc,
    output logic [ADDR_W-1:0]         id_pc4,
    output logic [5:0]                id_opcode,
    output logic [15:0]               id_imm16,
    input  logic                      redirect_valid,
    input  logic [ADDR_W-1:0]         redirect_pc
`ifdef IF_ALIGN_CHECK_EN
    , output logic                    if_misalign
`endif
);

    fetch_state_e      state;
    logic              drop;
    logic              redirect_take;
    logic              resp_ok;
    logic              advance;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc4;

    // A response is kept only if nothing has invalidated it, including a redirect this very cycle.
    assign resp_ok = imem.imem_rvalid && !drop && !redirect_take;
    assign advance = (state == S_WAIT) && resp_ok;

    fetch_pc_reg #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk            (clk),
        .rst_n          (rst_n),
        .advance        (advance),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .pc             (pc),
        .pc4            (pc4),
        .redirect_take  (redirect_take)
`ifdef IF_ALIGN_CHECK_EN
        , .misalign     (if_misalign)
`endif
    );

    assign imem.imem_req  = rst_n && (state == S_REQ);
    assign imem.imem_addr = pc;
    assign id_valid       = (state == S_HOLD);
    assign id_opcode      = id_instr[31:26];
    assign id_imm16       = id_instr[15:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_REQ;
            drop     <= 1'b0;
            id_instr <= INSTR_NOP;
            id_pc    <= '0;
            id_pc4   <= '0;
        end else begin
            unique case (state)
                S_REQ: begin
                    if (imem.imem_gnt) begin
                        state <= S_WAIT;
                        drop  <= redirect_take;
                    end
                end
                S_WAIT: begin
                    if (imem.imem_rvalid) begin
                        drop  <= 1'b0;
                        state <= resp_ok ? S_HOLD : S_REQ;
                        if (resp_ok) begin
                            id_instr <= imem.imem_rdata;
                            id_pc    <= pc;
                            id_pc4   <= pc4;
                        end
                    end else if (redirect_take) begin
                        drop <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (redirect_take || id_ready) state <= S_REQ;
                end
                default: state <= S_REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit; define IF_ALIGN_CHECK_EN to cover the alignment option.
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc4;
    logic [5:0]  id_opcode;
    logic [15:0] id_imm16;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
`ifdef IF_ALIGN_CHECK_EN
    logic        if_misalign;
`endif

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int cyc_mark;

    instr_fetch_unit_if #(.ADDR_W(32)) bus ();

    instr_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem           (bus),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .id_pc4         (id_pc4),
        .id_opcode      (id_opcode),
        .id_imm16       (id_imm16),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
`ifdef IF_ALIGN_CHECK_EN
        , .if_misalign  (if_misalign)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Request at addr, grant at once, respond next cycle; leaves the word held for decode.
    task automatic issue(input string name, input logic [31:0] addr, input logic [31:0] data);
        logic [31:0] p4;
        p4 = addr + 32'd4;
        check({name, "_req"}, 32'(bus.imem_req), 32'd1);
        check({name, "_addr"}, bus.imem_addr, addr);
        bus.imem_gnt = 1'b1;
        step();
        bus.imem_gnt = 1'b0;
        check({name, "_wait_req"}, 32'(bus.imem_req), 32'd0);
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = data;
        step();
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'h0;
        check({name, "_valid"}, 32'(id_valid), 32'd1);
        check({name, "_instr"}, id_instr, data);
        check({name, "_pc"}, id_pc, addr);
        check({name, "_pc4"}, id_pc4, p4);
    endtask

    task automatic accept(input string name);
        id_ready = 1'b1;
        step();
        id_ready = 1'b0;
        check({name, "_valid_clr"}, 32'(id_valid), 32'd0);
        check({name, "_req_again"}, 32'(bus.imem_req), 32'd1);
    endtask

    task automatic redirect_pulse(input logic [31:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
    endtask

    task automatic redirect_clear();
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
    endtask

    initial begin
        rst_n           = 1'b0;
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'h0;
        id_ready        = 1'b0;
        redirect_valid  = 1'b0;
        redirect_pc     = 32'h0;

        // Reset state
        step();
        step();
        check("rst_req", 32'(bus.imem_req), 32'd0);
        check("rst_valid", 32'(id_valid), 32'd0);
        check("rst_instr", id_instr, 32'h0);
        check("rst_pc", id_pc, 32'h0);
        check("rst_pc4", id_pc4, 32'h0);
        rst_n = 1'b1;
        #1;

        // Back-to-back fetches, three cycles each
        cyc_mark = cyc;
        issue("t1a", 32'h0, 32'h3C01_0001);
        accept("t1a");
        issue("t1b", 32'h4, 32'h3421_0002);
        accept("t1b");
        issue("t1c", 32'h8, 32'h0022_1820);
        accept("t1c");
        check("t1_cycles", 32'(cyc - cyc_mark), 32'd9);

        // Held instruction under back-pressure; stray rvalid ignored
        issue("t2", 32'hC, 32'h2008_FFFF);
        for (int i = 0; i < 5; i++) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = 32'hDEAD_BEEF;
            check("t2_valid", 32'(id_valid), 32'd1);
            check("t2_opcode", 32'(id_opcode), 32'h08);
            check("t2_imm16", 32'(id_imm16), 32'hFFFF);
            check("t2_instr", id_instr, 32'h2008_FFFF);
            check("t2_noreq", 32'(bus.imem_req), 32'd0);
            step();
        end
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'h0;
        accept("t2");
        check("t2_next_addr", bus.imem_addr, 32'h10);

        // Redirect while waiting; late response discarded
        bus.imem_gnt = 1'b1;
        step();
        bus.imem_gnt = 1'b0;
        redirect_pulse(32'h100);
        step();
        redirect_clear();
        check("t3_wait_req", 32'(bus.imem_req), 32'd0);
        step();
        step();
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'hDEAD_BEEF;
        step();
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'h0;
        check("t3_valid", 32'(id_valid), 32'd0);
        check("t3_req", 32'(bus.imem_req), 32'd1);
        check("t3_addr", bus.imem_addr, 32'h100);
        issue("t3f", 32'h100, 32'h2409_0005);
        accept("t3f");

        // Redirect in hold with simultaneous id_ready: instruction killed
        issue("t4", 32'h104, 32'h8C22_0004);
        id_ready = 1'b1;
        redirect_pulse(32'h200);
        step();
        id_ready = 1'b0;
        redirect_clear();
        check("t4_valid", 32'(id_valid), 32'd0);
        check("t4_addr", bus.imem_addr, 32'h200);
        step();
        check("t4_no_repeat", 32'(id_valid), 32'd0);
        issue("t4f", 32'h200, 32'hAC22_0008);
        accept("t4f");

        // Redirect in S_REQ without grant: new address next cycle
        redirect_pulse(32'h300);
        step();
        redirect_clear();
        check("rq_req", 32'(bus.imem_req), 32'd1);
        check("rq_addr", bus.imem_addr, 32'h300);

        // Redirect with grant in the same cycle: in-flight response dropped
        bus.imem_gnt = 1'b1;
        redirect_pulse(32'h400);
        step();
        bus.imem_gnt = 1'b0;
        redirect_clear();
        check("rg_wait", 32'(bus.imem_req), 32'd0);
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'h1111_1111;
        step();
        bus.imem_rvalid = 1'b0;
        check("rg_valid", 32'(id_valid), 32'd0);
        check("rg_addr", bus.imem_addr, 32'h400);

        // Redirect coinciding with rvalid: response dropped
        bus.imem_gnt = 1'b1;
        step();
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'h2222_2222;
        redirect_pulse(32'h500);
        step();
        bus.imem_rvalid = 1'b0;
        redirect_clear();
        check("rv_valid", 32'(id_valid), 32'd0);
        check("rv_req", 32'(bus.imem_req), 32'd1);
        check("rv_addr", bus.imem_addr, 32'h500);

        // PC wrap at the top of the address space
        redirect_pulse(32'hFFFF_FFFC);
        step();
        redirect_clear();
        issue("t5", 32'hFFFF_FFFC, 32'h0800_0040);
        accept("t5");
        check("t5_wrap_addr", bus.imem_addr, 32'h0);

        // Misaligned redirect in hold with id_ready
        issue("t6", 32'h0, 32'h3C1F_1234);
        id_ready = 1'b1;
        redirect_pulse(32'h102);
        step();
        id_ready = 1'b0;
        redirect_clear();
        check("t6_valid", 32'(id_valid), 32'd0);
`ifdef IF_ALIGN_CHECK_EN
        check("t6_misalign", 32'(if_misalign), 32'd1);
        check("t6_addr", bus.imem_addr, 32'h4);
        step();
        check("t6_misalign_clr", 32'(if_misalign), 32'd0);
`else
        check("t6_addr", bus.imem_addr, 32'h100);
`endif

        // Reset mid-fetch: stale response after reset ignored
        bus.imem_gnt = 1'b1;
        step();
        bus.imem_gnt = 1'b0;
        rst_n = 1'b0;
        step();
        check("mr_req_in_rst", 32'(bus.imem_req), 32'd0);
        rst_n = 1'b1;
        #1;
        check("mr_req", 32'(bus.imem_req), 32'd1);
        check("mr_addr", bus.imem_addr, 32'h0);
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'h3333_3333;
        step();
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'h0;
        check("mr_valid", 32'(id_valid), 32'd0);
        check("mr_still_req", 32'(bus.imem_req), 32'd1);
        issue("mrf", 32'h0, 32'h4444_4444);
        accept("mrf");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
